// File: rtl/gpc_column_accumulator.sv
// gpc_column_accumulator
//
// Takes the 4-bit words coming out of the (3,1,2) generalized parallel
// counter stage, weights each one by its column bit-offset, and adds them up
// into one wide sum per frame. A frame is any run of beats closed by a beat
// with in_last set. The finished sum is held in a registered valid/ready
// output slot, together with a sticky overflow flag and a saturating beat
// count.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready
//   in_o       4-bit unsigned GPC output word
//   in_shift   column bit-offset applied to in_o
//   in_last    beat closes the current frame
//   out_valid  result valid
//   out_ready  downstream takes the result when out_valid & out_ready
//   out_sum    frame sum modulo 2^ACC_W
//   out_ovf    frame sum needed more than ACC_W bits at some point
//   out_beats  beats in the frame, saturating at 2^CNT_W-1
module gpc_column_accumulator #(
    parameter int ACC_W   = 16,
    parameter int SHIFT_W = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_o,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_ovf,
    output logic [CNT_W-1:0]   out_beats
);

    // Wide enough that a 4-bit word shifted by the largest possible offset,
    // added to a full accumulator, can never lose a carry.
    localparam int FULL_W = ACC_W + 4 + (1 << SHIFT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ACC_W-1:0]  acc_q,       acc_d;
    logic              ovf_q,       ovf_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ACC_W-1:0]  out_sum_q,   out_sum_d;
    logic              out_ovf_q,   out_ovf_d;
    logic [CNT_W-1:0]  out_beats_q, out_beats_d;
    logic              out_valid_q, out_valid_d;

    logic [FULL_W-1:0] contrib;
    logic [FULL_W-1:0] full;
    logic [ACC_W-1:0]  acc_next;
    logic              ovf_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              in_accept;
    logic              out_accept;

    // A new beat may enter whenever the output slot is empty or is being
    // drained this very cycle, so back-to-back frames never see a bubble.
    assign in_ready   = ~out_valid_q | out_ready;
    assign in_accept  = in_valid & in_ready;
    assign out_accept = out_valid_q & out_ready;

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_beats = out_beats_q;

    // Work out what the running frame state would become if the current
    // input beat were accepted. Any bit landing at or above ACC_W, whether
    // from a carry or from a word shifted past the top, marks overflow.
    always_comb begin
        contrib  = {{(FULL_W-4){1'b0}}, in_o} << in_shift;
        full     = {{(FULL_W-ACC_W){1'b0}}, acc_q} + contrib;
        acc_next = full[ACC_W-1:0];
        ovf_next = ovf_q | (|full[FULL_W-1:ACC_W]);
        cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end

    // Decide the next value of every register. A last beat moves the
    // frame result into the output slot and wipes the running state so the
    // next frame starts from zero; a drained slot just drops valid and keeps
    // its data. When a last beat and a drain coincide, the load wins and
    // valid stays high.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_beats_d = out_beats_q;
        out_valid_d = out_valid_q;

        if (in_accept) begin
            if (in_last) begin
                out_sum_d   = acc_next;
                out_ovf_d   = ovf_next;
                out_beats_d = cnt_next;
                out_valid_d = 1'b1;
                acc_d       = '0;
                ovf_d       = 1'b0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_next;
                ovf_d = ovf_next;
                cnt_d = cnt_next;
            end
        end else if (out_accept) begin
            out_valid_d = 1'b0;
        end
    end

    // Running frame state. Reset throws away any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    // Output slot. Only this register set drives the out_* ports, so the
    // result is stable while downstream stalls and nothing on the input
    // side can reach the outputs combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_beats_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_beats_q <= out_beats_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_gpc_column_accumulator.sv
// tb_gpc_column_accumulator
//
// Directed and randomized checks for gpc_column_accumulator. The reference
// model keeps the exact (unbounded) frame total as a plain integer: the
// reported sum is that total modulo 2^16, overflow is simply "total reached
// 2^16", and the beat count is min(beats, 255).
module tb_gpc_column_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_o;
    logic [3:0]  in_shift;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_beats;

    int tests;
    int fails;

    longint modelTotal;
    int     modelBeats;
    logic [15:0] expSum;
    logic        expOvf;
    logic [7:0]  expBeats;

    gpc_column_accumulator #(
        .ACC_W  (16),
        .SHIFT_W(4),
        .CNT_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_o     (in_o),
        .in_shift (in_shift),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf),
        .out_beats(out_beats)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and on a miss count the failure and report.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fold one accepted beat into the model; a last beat publishes the
    // expected result and starts a fresh frame.
    task automatic modelAccept(input int o, input int shift, input bit last);
        modelTotal += longint'(o) << shift;
        modelBeats++;
        if (last) begin
            expSum     = modelTotal[15:0];
            expOvf     = (modelTotal >= 64'd65536);
            expBeats   = (modelBeats > 255) ? 8'd255 : 8'(modelBeats);
            modelTotal = 0;
            modelBeats = 0;
        end
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".sum"},   32'(out_sum),   32'(expSum));
        checkOutput({tag, ".ovf"},   32'(out_ovf),   32'(expOvf));
        checkOutput({tag, ".beats"}, 32'(out_beats), 32'(expBeats));
    endtask

    // Present one beat (called at a falling edge), wait a bounded time for
    // in_ready, let the rising edge take it, and return at the next falling
    // edge with in_valid dropped.
    task automatic applyStimulus(input int o, input int shift, input bit last);
        int waited;
        in_valid = 1'b1;
        in_o     = 4'(o);
        in_shift = 4'(shift);
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("beat_accept_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        modelAccept(o, shift, last);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        modelTotal = 0;
        modelBeats = 0;
        expSum     = '0;
        expOvf     = 1'b0;
        expBeats   = '0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_o       = '0;
        in_shift   = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // Reset state, sampled while reset is still held.
        repeat (2) @(negedge clk);
        checkOutput("rst.valid",    32'(out_valid), 32'd0);
        checkOutput("rst.sum",      32'(out_sum),   32'd0);
        checkOutput("rst.ovf",      32'(out_ovf),   32'd0);
        checkOutput("rst.beats",    32'(out_beats), 32'd0);
        checkOutput("rst.in_ready", 32'(in_ready),  32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Basic three-beat frame; valid pulses for one cycle.
        applyStimulus(5, 0, 1'b0);
        applyStimulus(3, 4, 1'b0);
        applyStimulus(1, 8, 1'b1);
        checkResult("basic");
        checkOutput("basic.const_sum", 32'(out_sum), 32'h0135);
        @(negedge clk);
        checkOutput("basic.pulse_end", 32'(out_valid), 32'd0);

        // Overflow frame, then a clean frame must not inherit the flag.
        applyStimulus(15, 12, 1'b0);
        applyStimulus(15, 12, 1'b1);
        checkResult("ovf");
        checkOutput("ovf.const_sum", 32'(out_sum), 32'hE000);
        checkOutput("ovf.const_flag", 32'(out_ovf), 32'd1);
        applyStimulus(1, 0, 1'b1);
        checkResult("ovf_clear");
        checkOutput("ovf_clear.const_flag", 32'(out_ovf), 32'd0);
        @(negedge clk);

        // Backpressure: result held, pending beat blocked and outputs frozen.
        out_ready = 1'b0;
        applyStimulus(4, 1, 1'b0);
        applyStimulus(2, 0, 1'b1);
        checkResult("bp");
        checkOutput("bp.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_o     = 4'd9;
        in_shift = 4'd3;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkResult("bp.hold");
            checkOutput("bp.hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp.release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        modelAccept(9, 3, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkResult("bp.released");
        checkOutput("bp.const_sum", 32'(out_sum), 32'd72);

        // Drain and load in the same cycle: no bubble in out_valid.
        applyStimulus(7, 2, 1'b1);
        checkResult("simul");
        checkOutput("simul.const_sum", 32'(out_sum), 32'h001C);
        @(negedge clk);
        checkOutput("simul.drained", 32'(out_valid), 32'd0);

        // Randomized frames with occasional downstream stalls.
        for (int f = 0; f < 40; f++) begin
            int len;
            logic stall;
            logic [15:0] heldSum;
            len   = $urandom_range(1, 8);
            stall = 1'($urandom_range(0, 1));
            out_ready = ~stall;
            for (int b = 1; b <= len; b++) begin
                applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), b == len);
            end
            checkResult("rand");
            if (stall) begin
                heldSum = expSum;
                repeat (2) @(negedge clk);
                checkOutput("rand.stall_sum", 32'(out_sum), 32'(heldSum));
                checkOutput("rand.stall_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b1;
            end
            @(negedge clk);
            checkOutput("rand.drained", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b1;

        // Beat counter saturation over a 300-beat frame.
        for (int b = 1; b <= 300; b++) begin
            applyStimulus(1, 0, b == 300);
        end
        checkResult("sat");
        checkOutput("sat.const_sum",   32'(out_sum),   32'd300);
        checkOutput("sat.const_beats", 32'(out_beats), 32'd255);
        @(negedge clk);

        // Asynchronous reset in the middle of a frame.
        applyStimulus(3, 1, 1'b0);
        applyStimulus(6, 2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst.valid", 32'(out_valid), 32'd0);
        checkOutput("midrst.sum",   32'(out_sum),   32'd0);
        checkOutput("midrst.ovf",   32'(out_ovf),   32'd0);
        checkOutput("midrst.beats", 32'(out_beats), 32'd0);
        #1;
        rst = 1'b0;
        modelTotal = 0;
        modelBeats = 0;
        @(negedge clk);
        applyStimulus(2, 0, 1'b1);
        checkResult("postrst");
        checkOutput("postrst.const_sum",   32'(out_sum),   32'd2);
        checkOutput("postrst.const_beats", 32'(out_beats), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
